// File: rtl/jam_pkg.sv
// jam_pkg: shared widths, default burst limit and arbiter state encoding.
package jam_pkg;
    localparam int IDX_W = 3;
    localparam int COST_W = 7;
    localparam int DEFAULT_MAX_BURST = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick; ptr names the requester favoured on contention.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);
    assign gnt[0] = req[0] & (~req[1] | ~ptr);
    assign gnt[1] = req[1] & (~req[0] | ptr);
endmodule

// File: rtl/cost_arb.sv
// cost_arb: arbitrates two requesters onto a shared cost table with optional locked bursts.
import jam_pkg::*;
module cost_arb #(
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              req1,
    input  logic [IDX_W-1:0]  w0,
    input  logic [IDX_W-1:0]  w1,
    input  logic [IDX_W-1:0]  j0,
    input  logic [IDX_W-1:0]  j1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvld0,
    output logic              rvld1,
    output logic [COST_W-1:0] rcost0,
    output logic [COST_W-1:0] rcost1,
    output logic [IDX_W-1:0]  W,
    output logic [IDX_W-1:0]  J,
    input  logic [COST_W-1:0] Cost
);
    localparam logic [3:0] MB = 4'(MAX_BURST);
    state_t state;
    logic ptr;
    logic [3:0] cnt;
    logic [1:0] pick, gnt;
    logic own, rk, lk;
    rr_arb2 u_arb (.req({req1, req0}), .ptr, .gnt(pick));
    always_comb begin
        gnt = RST ? 2'b00 : state == OWN0 ? {1'b0, req0} : state == OWN1 ? {req1, 1'b0} : pick;
        own = state == OWN1;
        rk = own ? req1 : req0;
        lk = gnt[1] ? lock1 : lock0;
    end
    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];
    assign W = gnt[0] ? w0 : gnt[1] ? w1 : '0;
    assign J = gnt[0] ? j0 : gnt[1] ? j1 : '0;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            ptr <= 1'b0;
            cnt <= '0;
            rvld0 <= 1'b0;
            rvld1 <= 1'b0;
            rcost0 <= '0;
            rcost1 <= '0;
        end else begin
            rvld0 <= gnt[0];
            rvld1 <= gnt[1];
            if (gnt[0]) rcost0 <= Cost;
            if (gnt[1]) rcost1 <= Cost;
            if (state == IDLE) begin
                // the entry beat already counts toward the burst
                if (|gnt && lk && MB != 4'd1) begin
                    state <= gnt[1] ? OWN1 : OWN0;
                    cnt <= 4'd1;
                end else if (|gnt) begin
                    ptr <= ~gnt[1];
                end
            end else if (!rk || !lk || cnt + 4'd1 == MB) begin
                state <= IDLE;
                ptr <= ~own;
                cnt <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_cost_arb.sv
// tb_cost_arb: scoreboard bench; expected lookups are queued at grant and retired at rvld.
module tb_cost_arb;
    import jam_pkg::*;
    logic CLK = 1'b0, RST = 1'b1;
    logic req0 = 0, req1 = 0, lock0 = 0, lock1 = 0;
    logic [2:0] w0 = 0, w1 = 0, j0 = 0, j1 = 0;
    logic gnt0, gnt1, rvld0, rvld1;
    logic [6:0] rcost0, rcost1, Cost;
    logic [2:0] W, J;
    typedef struct {logic k; logic [6:0] c;} exp_t;
    exp_t q[$];
    int errs = 0, checks = 0;
    logic [6:0] erc0 = 0, erc1 = 0;
    bit hold_idx = 0;

    cost_arb dut (
        .CLK(CLK), .RST(RST), .req0(req0), .req1(req1), .w0(w0), .w1(w1), .j0(j0), .j1(j1),
        .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1), .rvld0(rvld0), .rvld1(rvld1),
        .rcost0(rcost0), .rcost1(rcost1), .W(W), .J(J), .Cost(Cost)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] cost_of(input logic [2:0] w, input logic [2:0] j);
        return 7'(int'(w) * 11 + int'(j) * 3);
    endfunction

    assign Cost = cost_of(W, J);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sample_rvld();
        exp_t e;
        logic [1:0] ev;
        ev = 2'b00;
        if (q.size() > 0) begin
            e = q.pop_front();
            ev[e.k] = 1'b1;
            if (e.k) erc1 = e.c;
            else erc0 = e.c;
        end
        check("rvld0", 32'(rvld0), 32'(ev[0]));
        check("rvld1", 32'(rvld1), 32'(ev[1]));
        check("rcost0", 32'(rcost0), 32'(erc0));
        check("rcost1", 32'(rcost1), 32'(erc1));
    endtask

    task automatic cyc(input logic r0, input logic r1, input logic l0, input logic l1, input logic [1:0] eg);
        logic [2:0] ew, ej;
        req0 = r0; req1 = r1; lock0 = l0; lock1 = l1;
        if (!hold_idx) begin
            w0 = 3'($urandom); j0 = 3'($urandom); w1 = 3'($urandom); j1 = 3'($urandom);
        end
        #3;
        sample_rvld();
        check("gnt0", 32'(gnt0), 32'(eg[0]));
        check("gnt1", 32'(gnt1), 32'(eg[1]));
        ew = eg[0] ? w0 : eg[1] ? w1 : 3'd0;
        ej = eg[0] ? j0 : eg[1] ? j1 : 3'd0;
        check("W", 32'(W), 32'(ew));
        check("J", 32'(J), 32'(ej));
        if (eg[0]) q.push_back('{1'b0, cost_of(w0, j0)});
        if (eg[1]) q.push_back('{1'b1, cost_of(w1, j1)});
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_gnt"}, 32'({gnt1, gnt0}), 0);
        check({tag, "_rvld"}, 32'({rvld1, rvld0}), 0);
        check({tag, "_rcost0"}, 32'(rcost0), 0);
        check({tag, "_rcost1"}, 32'(rcost1), 0);
        check({tag, "_WJ"}, 32'({W, J}), 0);
    endtask

    task automatic do_reset(input string tag);
        RST = 1'b1;
        #1;
        reset_checks(tag);
        q.delete();
        erc0 = 0;
        erc1 = 0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    endtask

    initial begin
        #2;
        reset_checks("por");
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        // single requester with fixed indices, then an idle cycle to see rvld and hold
        hold_idx = 1;
        w0 = 3'd2; j0 = 3'd5; w1 = 3'd7; j1 = 3'd7;
        cyc(1, 0, 0, 0, 2'b01);
        check("cost37", 32'(cost_of(3'd2, 3'd5)), 37);
        cyc(0, 0, 0, 0, 2'b00);
        w0 = 3'd6; j0 = 3'd1;
        cyc(0, 0, 0, 0, 2'b00);
        hold_idx = 0;
        // alternating contention
        do_reset("r1");
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, (i % 2 == 0) ? 2'b01 : 2'b10);
        cyc(0, 0, 0, 0, 2'b00);
        // locked burst released by lock0=0
        do_reset("r2");
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 2'b01);
        cyc(1, 1, 0, 0, 2'b01);
        cyc(1, 1, 0, 0, 2'b10);
        cyc(0, 0, 0, 0, 2'b00);
        // burst cap
        do_reset("r3");
        for (int i = 1; i <= 12; i++) cyc(1, 1, 1, 0, (i == 9) ? 2'b10 : 2'b01);
        cyc(0, 1, 0, 0, 2'b00);
        cyc(0, 1, 0, 0, 2'b10);
        cyc(0, 0, 0, 0, 2'b00);
        // owner idles in OWN1 while requester 0 waits
        do_reset("r4");
        cyc(0, 1, 0, 1, 2'b10);
        cyc(1, 1, 0, 1, 2'b10);
        cyc(1, 0, 0, 0, 2'b00);
        cyc(1, 1, 0, 0, 2'b01);
        cyc(1, 1, 0, 0, 2'b10);
        cyc(0, 0, 0, 0, 2'b00);
        // lock without request is ignored
        do_reset("r5");
        cyc(0, 1, 1, 0, 2'b10);
        cyc(1, 1, 0, 0, 2'b01);
        cyc(1, 1, 0, 0, 2'b10);
        cyc(0, 0, 0, 0, 2'b00);
        // reset during the third locked beat
        do_reset("r6");
        cyc(1, 1, 1, 0, 2'b01);
        cyc(1, 1, 1, 0, 2'b01);
        req0 = 1; req1 = 1; lock0 = 1;
        do_reset("mid");
        cyc(1, 1, 0, 0, 2'b01);
        cyc(1, 1, 0, 0, 2'b10);
        cyc(0, 0, 0, 0, 2'b00);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/cost_arb.md
COST_ARB -- requirements
Module: cost_arb

Interface
REQ-001 The block SHALL have one parameter: MAX_BURST, default 8, the maximum consecutive locked grants to one requester.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high. Ports are listed as name, direction, width, meaning.
REQ-003 CLK  in  1  sole clock, all state updates on its rising edge.
REQ-004 RST  in  1  asynchronous active-high reset.
REQ-005 req0/req1  in  1  requester k wants one cost lookup this cycle.
REQ-006 w0/w1  in  3  worker index of requester k.
REQ-007 j0/j1  in  3  job index of requester k.
REQ-008 lock0/lock1  in  1  requester k asks to keep ownership after this beat.
REQ-009 gnt0/gnt1  out  1  combinational grant; the lookup is taken this cycle.
REQ-010 rvld0/rvld1  out  1  registered pulse; rcost_k holds the returned cost.
REQ-011 rcost0/rcost1  out  7  cost captured for requester k.
REQ-012 W  out  3  worker index driven to the shared cost table.
REQ-013 J  out  3  job index driven to the shared cost table.
REQ-014 Cost  in  7  combinational table data for the current W/J.

Function
REQ-015 The block SHALL grant at most one requester per cycle; gnt0 and gnt1 are never both 1.
REQ-016 A grant SHALL require req_k=1 and RST=0.
REQ-017 With no owner and a single requester, that requester SHALL be granted.
REQ-018 With no owner and both requesting, the requester selected by a 1-bit round-robin pointer SHALL be granted.
REQ-019 After an unlocked grant to k, the pointer SHALL point to the other requester.
REQ-020 W/J SHALL equal w_k/j_k of the granted requester, otherwise 3'd0.
REQ-021 On a grant edge, Cost SHALL be captured into rcost_k, and rvld_k SHALL be 1 for exactly the next cycle (latency 1).
REQ-022 rcost_k SHALL hold its value until the next grant to k.
REQ-023 The FSM SHALL have states IDLE, OWN0 and OWN1.
REQ-024 The FSM SHALL move from IDLE to OWNk on a grant to k with lock_k=1.
REQ-025 In OWNk, only requester k SHALL be granted; the other requester is stalled (gnt=0) even if k idles.
REQ-026 The FSM SHALL return from OWNk to IDLE on a grant with lock_k=0, on req_k=0, or when the burst count reaches MAX_BURST.
REQ-027 On any return from OWNk to IDLE, the pointer SHALL be set to the other requester.
REQ-028 A 4-bit burst counter SHALL be cleared on entry to OWNk and incremented per granted beat.
REQ-029 At the grant that makes the burst count equal MAX_BURST, ownership SHALL be released regardless of lock_k (wrap-around guard).
REQ-030 When req_k drops in OWNk, the FSM SHALL go to IDLE on the next edge, with no grant that cycle.
REQ-031 lock_k with req_k=0 SHALL be ignored.
REQ-032 A change of w_k/j_k while not granted SHALL have no effect.

Reset
REQ-033 While RST=1: state=IDLE, pointer=0, burst counter=0, gnt0=gnt1=0, rvld0=rvld1=0, rcost0=rcost1=7'd0, W=J=3'd0.
REQ-034 Reset asserted mid-burst SHALL abort ownership; no rvld SHALL be produced for the aborted beat.
REQ-035 The first cycle after reset release with both requesting SHALL grant requester 0.

Structure
REQ-036 The shared package jam_pkg SHALL hold IDX_W=3, COST_W=7, DEFAULT_MAX_BURST=8 and the state encoding type (IDLE=0, OWN0=1, OWN1=2).
REQ-037 A single sub-module rr_arb2 SHALL implement the 2-way round-robin pick (inputs req, pointer; output one-hot grant).
REQ-038 The FSM, counter and capture registers SHALL stay in cost_arb.

Verification
REQ-039 Single requester: req0=1, w0=2, j0=5, Cost=37, lock0=0 -> gnt0=1, W=2, J=5 same cycle; next cycle rvld0=1, rcost0=37.
REQ-040 Contention after reset: both req, lock=0 for 4 cycles -> grants alternate 0,1,0,1; each rvld_k follows one cycle later.
REQ-041 Lock burst: req0=lock0=1 for 3 beats, then lock0=0 on the 4th, with req1=1 throughout -> gnt0 for 4 cycles, then gnt1 on the 5th.
REQ-042 Burst cap: req0=lock0=1 held for 12 cycles, req1=1 -> gnt0 cycles 1-8, gnt1 cycle 9, gnt0 cycle 10.
REQ-043 Owner idle: in OWN1, req1=0 for one cycle, req0=1 -> no grant that cycle, gnt0 next cycle.
REQ-044 Reset mid-burst: RST pulse during OWN0 beat 3 -> all outputs 0 immediately, no rvld0, and the next contention grants requester 0.
